// File: rtl/fb_line_reader.sv
// fb_line_reader: display-side framebuffer read master that streams one LEN-pixel line per request into the linebuffer.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous active-high reset
//   i_frame_start  1-cycle pulse at start of vertical blanking; rewinds to line 0 and aborts any fetch
//   i_line_req     1-cycle pulse requesting the next line
//   o_fb_addr      framebuffer read address
//   i_fb_data      framebuffer read data, valid LAT cycles after o_fb_addr
//   o_dout         pixel colour index to linebuffer (registered from i_fb_data)
//   o_dout_en      o_dout valid
//   o_busy         line fetch in progress
//   o_frame_done   1-cycle pulse after the last pixel of line LINES-1
// Optional (macro FB_LINE_READER_OVERRUN_EN):
//   o_overrun      sticky flag, a line request was dropped
//   o_overrun_cnt  dropped request count, saturating at 255
module fb_line_reader #(
    parameter int LEN   = 320,
    parameter int LINES = 240,
    parameter int ADDRW = 17,
    parameter int DATAW = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_start,
    input  logic             i_line_req,
    output logic [ADDRW-1:0] o_fb_addr,
    input  logic [DATAW-1:0] i_fb_data,
    output logic [DATAW-1:0] o_dout,
    output logic             o_dout_en,
    output logic             o_busy,
    output logic             o_frame_done
`ifdef FB_LINE_READER_OVERRUN_EN
    ,
    output logic             o_overrun,
    output logic [7:0]       o_overrun_cnt
`endif
);
    localparam int CW = $clog2(LINES + 1);
    localparam int PW = $clog2(LEN + 1);
    localparam int DW = $clog2(LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_line_cnt;
    logic [ADDRW-1:0] r_base;
    logic [PW-1:0]   r_pix_cnt;
    logic [DW-1:0]   r_drain_cnt;
    logic [LAT:0]    r_vld;
    logic            w_start, w_last_pix, w_drain_done;

    // frame_start rewinds first, so a same-cycle request always starts line 0
    assign w_start      = i_line_req && (i_frame_start || (r_state == IDLE && r_line_cnt < CW'(LINES)));
    assign w_last_pix   = r_state == READ && r_pix_cnt == PW'(LEN - 1);
    assign w_drain_done = r_state == DRAIN && r_drain_cnt == DW'(LAT);
    assign o_dout_en    = r_vld[LAT];
    assign o_busy       = r_state != IDLE;

    always_comb begin
        w_state_nxt = r_state;
        if (w_start)
            w_state_nxt = READ;
        else if (i_frame_start)
            w_state_nxt = IDLE;
        else if (w_last_pix)
            w_state_nxt = DRAIN;
        else if (w_drain_done)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_line_cnt   <= '0;
            r_base       <= '0;
            r_pix_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_vld        <= '0;
            o_fb_addr    <= '0;
            o_dout       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            o_dout       <= i_fb_data;
            // each issued address is tagged; the tag emerges with its pixel
            r_vld        <= i_frame_start ? '0 : {r_vld[LAT-1:0], r_state == READ};
            r_drain_cnt  <= r_state == DRAIN ? r_drain_cnt + DW'(1) : '0;
            o_frame_done <= w_drain_done && !i_frame_start && r_line_cnt == CW'(LINES - 1);
            if (i_frame_start) begin
                r_line_cnt <= '0;
                r_base     <= '0;
            end else if (w_drain_done) begin
                r_line_cnt <= r_line_cnt + CW'(1);
                // base stops at the last line so it never points past the frame
                if (r_line_cnt != CW'(LINES - 1))
                    r_base <= r_base + ADDRW'(LEN);
            end
            if (w_start) begin
                o_fb_addr <= i_frame_start ? '0 : r_base;
                r_pix_cnt <= '0;
            end else if (r_state == READ && !i_frame_start && !w_last_pix) begin
                o_fb_addr <= o_fb_addr + ADDRW'(1);
                r_pix_cnt <= r_pix_cnt + PW'(1);
            end
        end
    end

`ifdef FB_LINE_READER_OVERRUN_EN
    logic w_drop;
    assign w_drop = i_line_req && !w_start;
    always_ff @(posedge clk) begin
        if (rst || i_frame_start) begin
            o_overrun     <= 1'b0;
            o_overrun_cnt <= '0;
        end else if (w_drop) begin
            o_overrun     <= 1'b1;
            o_overrun_cnt <= o_overrun_cnt == 8'hFF ? o_overrun_cnt : o_overrun_cnt + 8'd1;
        end
    end
`endif
endmodule
